// File: rtl/mant_div_seq.sv
// mant_div_seq: sequential restoring radix-2 mantissa divider.
// Computes quot = floor(A*2^MW / B) and rem = (A*2^MW) mod B, where
// A = {1, in1_frac} and B = {1, in2_frac}, one quotient bit per cycle,
// MSB first. Valid/ready handshake on both sides, synchronous abort.
module mant_div_seq #(
   parameter  int MW = 24,
   localparam int QW = MW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [MW-2:0] in1_frac,
   input  logic [MW-2:0] in2_frac,
   input  logic          abort,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [QW-1:0] quot,
   output logic [MW-1:0] rem,
   output logic          sticky
);

   localparam int CW = $clog2(QW);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [MW-1:0] div_r;
   logic [MW:0]   rem_r;
   logic [QW-1:0] quot_r;

   logic [MW+1:0] diff;
   logic          ge;
   logic [MW:0]   rem_nxt;

   // Trial subtraction: the extra top bit of diff is the borrow, so a
   // partial remainder up to 2*(B-1) compares correctly against B.
   always_comb begin
      diff    = {1'b0, rem_r} - {2'b00, div_r};
      ge      = ~diff[MW+1];
      rem_nxt = ge ? diff[MW:0] : rem_r;
   end

   // Control FSM and datapath: load on accept, iterate QW times, hold in DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         div_r  <= '0;
         rem_r  <= '0;
         quot_r <= '0;
      end else if (abort) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  state  <= BUSY;
                  div_r  <= {1'b1, in2_frac};
                  rem_r  <= {2'b01, in1_frac};
                  quot_r <= '0;
                  cnt    <= CW'(QW - 1);
               end
            end
            BUSY: begin
               quot_r <= {quot_r[QW-2:0], ge};
               if (cnt == '0) begin
                  // Last bit has weight 2^0: keep the remainder unshifted.
                  rem_r <= rem_nxt;
                  state <= DONE;
               end else begin
                  // rem_nxt < B < 2^MW here, so dropping its top bit is lossless.
                  rem_r <= {rem_nxt[MW-1:0], 1'b0};
                  cnt   <= cnt - 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Handshake and result outputs.
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      quot      = quot_r;
      rem       = rem_r[MW-1:0];
      sticky    = |rem_r[MW-1:0];
   end

endmodule
